// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb.sv
// Two-requester (fetch / data) arbiter onto one shared memory port,
// with alternating priority and a per-grant bus timeout.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [SEL_W-1:0]  dm_sel_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [SEL_W-1:0]  bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              stallreq_o,
  output logic              err_o
);

  // The last permitted wait-count value; reaching it without ack ends the grant.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_r, state_s;
  logic              last_dm_r, last_dm_s;
  logic [7:0]        cnt_r, cnt_s;
  logic              if_req_eff_s, dm_req_eff_s;
  logic              grant_if_s, grant_dm_s, done_s, tmo_s;

  logic              we_r;
  logic [SEL_W-1:0]  sel_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] if_rdata_r, dm_rdata_r;
  logic              if_ack_r, dm_ack_r, err_r;

  // A requester in its ack cycle is still holding req; mask it so it is not regranted.
  assign if_req_eff_s = if_req_i & ~if_ack_r;
  assign dm_req_eff_s = dm_req_i & ~dm_ack_r;

  // State, priority flag and wait counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      last_dm_r <= 1'b0;
      cnt_r     <= 8'd0;
    end else begin
      state_r   <= state_s;
      last_dm_r <= last_dm_s;
      cnt_r     <= cnt_s;
    end
  end

  // Next-state, arbitration and timeout decisions.
  always_comb begin
    state_s    = state_r;
    last_dm_s  = last_dm_r;
    cnt_s      = cnt_r;
    grant_if_s = 1'b0;
    grant_dm_s = 1'b0;
    done_s     = 1'b0;
    tmo_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (dm_req_eff_s && (!if_req_eff_s || !last_dm_r)) begin
          grant_dm_s = 1'b1;
          state_s    = GNT_DM;
          last_dm_s  = 1'b1;
          cnt_s      = 8'd0;
        end else if (if_req_eff_s) begin
          grant_if_s = 1'b1;
          state_s    = GNT_IF;
          last_dm_s  = 1'b0;
          cnt_s      = 8'd0;
        end else begin
          state_s    = IDLE;
        end
      end
      GNT_IF, GNT_DM: begin
        if (bus_ack_i) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else if (cnt_r == TMO_LAST) begin
          tmo_s   = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Request latch, read-data capture and completion pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r       <= 1'b0;
      sel_r      <= 4'h0;
      addr_r     <= 32'h0;
      wdata_r    <= 32'h0;
      if_rdata_r <= 32'h0;
      dm_rdata_r <= 32'h0;
      if_ack_r   <= 1'b0;
      dm_ack_r   <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      if (grant_if_s) begin
        we_r    <= 1'b0;
        sel_r   <= 4'hF;
        addr_r  <= if_addr_i;
        wdata_r <= 32'h0;
      end else if (grant_dm_s) begin
        we_r    <= dm_we_i;
        sel_r   <= dm_sel_i;
        addr_r  <= dm_addr_i;
        wdata_r <= dm_wdata_i;
      end
      if (state_r == GNT_IF && done_s) begin
        if_rdata_r <= bus_rdata_i;
      end else if (state_r == GNT_IF && tmo_s) begin
        if_rdata_r <= 32'h0;
      end
      // Write completions keep the previous read value visible.
      if (state_r == GNT_DM && done_s && !we_r) begin
        dm_rdata_r <= bus_rdata_i;
      end else if (state_r == GNT_DM && tmo_s) begin
        dm_rdata_r <= 32'h0;
      end
      if_ack_r <= (done_s | tmo_s) & (state_r == GNT_IF);
      dm_ack_r <= (done_s | tmo_s) & (state_r == GNT_DM);
      err_r    <= tmo_s;
    end
  end

  assign bus_req_o   = (state_r == GNT_IF) || (state_r == GNT_DM);
  assign bus_we_o    = we_r;
  assign bus_sel_o   = sel_r;
  assign bus_addr_o  = addr_r;
  assign bus_wdata_o = wdata_r;
  assign if_rdata_o  = if_rdata_r;
  assign dm_rdata_o  = dm_rdata_r;
  assign if_ack_o    = if_ack_r;
  assign dm_ack_o    = dm_ack_r;
  assign err_o       = err_r;
  assign stallreq_o  = (if_req_i & ~if_ack_r) | (dm_req_i & ~dm_ack_r);

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb, built with a 4-cycle timeout.
module tb_mem_arb;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [3:0]  dm_sel_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stallreq_o;
  logic        err_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_arb #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stallreq_o(stallreq_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_sel_i = 4'h0;
    dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
    bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
    #1;
    check("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
    check("rst_if_ack", {31'd0, if_ack_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);
    check("rst_stall", {31'd0, stallreq_o}, 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'h0);
    tick();
    tick();

    // Single fetch with bus_ack tied high: minimum latency
    rst = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h2402_0001;
    check("idle_ack_ignored", {31'd0, if_ack_o}, 32'd0);
    tick();
    check("f_bus_req", {31'd0, bus_req_o}, 32'd1);
    check("f_bus_addr", bus_addr_o, 32'h0000_0010);
    check("f_bus_sel", {28'd0, bus_sel_o}, 32'hF);
    check("f_bus_we", {31'd0, bus_we_o}, 32'd0);
    check("f_stall", {31'd0, stallreq_o}, 32'd1);
    check("f_ack_early", {31'd0, if_ack_o}, 32'd0);
    tick();
    check("f_ack", {31'd0, if_ack_o}, 32'd1);
    check("f_rdata", if_rdata_o, 32'h2402_0001);
    check("f_bus_req_off", {31'd0, bus_req_o}, 32'd0);
    check("f_stall_off", {31'd0, stallreq_o}, 32'd0);
    tick();
    check("f_no_regrant", {31'd0, bus_req_o}, 32'd0);
    check("f_ack_pulse", {31'd0, if_ack_o}, 32'd0);
    if_req_i = 1'b0;
    bus_ack_i = 1'b0;
    tick();

    // Simultaneous requests: DM first, then IF
    if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h0000_0200;
    tick();
    check("b_dm_first_addr", bus_addr_o, 32'h0000_0200);
    check("b_bus_req", {31'd0, bus_req_o}, 32'd1);
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    tick();
    check("b_dm_ack", {31'd0, dm_ack_o}, 32'd1);
    check("b_if_ack_quiet", {31'd0, if_ack_o}, 32'd0);
    check("b_dm_rdata", dm_rdata_o, 32'h1111_2222);
    check("b_stall_if_pending", {31'd0, stallreq_o}, 32'd1);
    dm_req_i = 1'b0; bus_rdata_i = 32'h3333_4444;
    tick();
    check("b_if_addr", bus_addr_o, 32'h0000_0040);
    check("b_dm_ack_pulse", {31'd0, dm_ack_o}, 32'd0);
    check("b_if_ack_early", {31'd0, if_ack_o}, 32'd0);
    tick();
    check("b_if_ack", {31'd0, if_ack_o}, 32'd1);
    check("b_dm_ack_quiet", {31'd0, dm_ack_o}, 32'd0);
    check("b_if_rdata", if_rdata_o, 32'h3333_4444);
    if_req_i = 1'b0; bus_ack_i = 1'b0;
    tick();

    // DM write, ack arrives in the fourth (timeout-boundary) granted cycle
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_sel_i = 4'b0011;
    dm_addr_i = 32'h0000_0100; dm_wdata_i = 32'hDEAD_BEEF;
    bus_rdata_i = 32'hCAFE_F00D;
    tick();
    check("w_bus_we", {31'd0, bus_we_o}, 32'd1);
    check("w_bus_sel", {28'd0, bus_sel_o}, 32'h3);
    check("w_bus_addr", bus_addr_o, 32'h0000_0100);
    check("w_bus_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      check("w_stall_wait", {31'd0, stallreq_o}, 32'd1);
      check("w_ack_wait", {31'd0, dm_ack_o}, 32'd0);
      tick();
    end
    check("w_bus_req_held", {31'd0, bus_req_o}, 32'd1);
    bus_ack_i = 1'b1;
    tick();
    check("w_dm_ack", {31'd0, dm_ack_o}, 32'd1);
    check("w_no_err", {31'd0, err_o}, 32'd0);
    check("w_rdata_kept", dm_rdata_o, 32'h1111_2222);
    check("w_stall_off", {31'd0, stallreq_o}, 32'd0);
    dm_req_i = 1'b0; dm_we_i = 1'b0; bus_ack_i = 1'b0;
    tick();

    // Fetch timeout after four wait cycles
    if_req_i = 1'b1; if_addr_i = 32'h0000_0080;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t_bus_req", {31'd0, bus_req_o}, 32'd1);
      check("t_err_wait", {31'd0, err_o}, 32'd0);
      check("t_ack_wait", {31'd0, if_ack_o}, 32'd0);
      tick();
    end
    check("t_if_ack", {31'd0, if_ack_o}, 32'd1);
    check("t_err", {31'd0, err_o}, 32'd1);
    check("t_if_rdata", if_rdata_o, 32'h0);
    check("t_bus_req_off", {31'd0, bus_req_o}, 32'd0);
    if_req_i = 1'b0;
    tick();
    check("t_err_pulse", {31'd0, err_o}, 32'd0);
    check("t_idle", {31'd0, bus_req_o}, 32'd0);

    // Reset in the second GNT_DM cycle, then reissue
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_sel_i = 4'hF; dm_addr_i = 32'h0000_0300;
    tick();
    tick();
    check("r_bus_req_pre", {31'd0, bus_req_o}, 32'd1);
    rst = 1'b0;
    #1;
    check("r_bus_req", {31'd0, bus_req_o}, 32'd0);
    check("r_dm_ack", {31'd0, dm_ack_o}, 32'd0);
    check("r_err", {31'd0, err_o}, 32'd0);
    tick();
    check("r_held_ack", {31'd0, dm_ack_o}, 32'd0);
    check("r_held_err", {31'd0, err_o}, 32'd0);
    rst = 1'b1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h55AA_55AA;
    tick();
    check("r2_bus_req", {31'd0, bus_req_o}, 32'd1);
    check("r2_bus_addr", bus_addr_o, 32'h0000_0300);
    tick();
    check("r2_dm_ack", {31'd0, dm_ack_o}, 32'd1);
    check("r2_dm_rdata", dm_rdata_o, 32'h55AA_55AA);
    check("r2_err", {31'd0, err_o}, 32'd0);
    dm_req_i = 1'b0; bus_ack_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the bus-cycle limit per grant (range 1..255).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 if_req_i/if_addr_i  in  1/32  SHALL carry the fetch request and its word address.
REQ-005 if_rdata_o/if_ack_o  out  32/1  SHALL return the fetch data with a one-cycle completion pulse.
REQ-006 dm_req_i/dm_we_i/dm_sel_i/dm_addr_i/dm_wdata_i  in  1/1/4/32/32  SHALL carry the data access: request, write enable, byte lanes, address, write data.
REQ-007 dm_rdata_o/dm_ack_o  out  32/1  SHALL return the data-read value with a one-cycle completion pulse.
REQ-008 bus_req_o/bus_we_o/bus_sel_o/bus_addr_o/bus_wdata_o  out  1/1/4/32/32  SHALL drive the shared memory port.
REQ-009 bus_rdata_i/bus_ack_i  in  32/1  SHALL return the memory read data and completion.
REQ-010 stallreq_o  out  1  SHALL request a pipeline stall while any request is pending.
REQ-011 err_o  out  1  SHALL pulse for one cycle on a timed-out access.

Function
REQ-012 FSM states SHALL be IDLE, GNT_IF and GNT_DM.
REQ-013 In IDLE with only one request valid, that requester SHALL be granted on the next edge.
REQ-014 Both requests valid SHALL grant the one not granted last (last_gnt flag, reset value IF, so DM wins first).
REQ-015 On grant, the requester's address, we, sel and wdata SHALL be latched; bus_* outputs SHALL be driven from the latch, and fetches SHALL drive we=0, sel=4'hF, wdata=0.
REQ-016 bus_req_o SHALL be 1 exactly while the state is GNT_IF or GNT_DM.
REQ-017 bus_ack_i=1 in GNT_x SHALL register bus_rdata_i into x_rdata_o, pulse x_ack_o for exactly one cycle, and return to IDLE.
REQ-018 Minimum latency: request sampled at edge N gives bus_req_o from N+1; bus_ack_i during cycle N+1 gives x_ack_o during cycle N+2.
REQ-019 x_rdata_o SHALL hold its value until the next completion for that requester; a DM write completion SHALL leave dm_rdata_o unchanged.
REQ-020 During the cycle that x_ack_o=1, x_req_i SHALL be ignored for arbitration, so a held request is not regranted.
REQ-021 Requesters SHALL hold req and all request fields stable until their ack; the arbiter SHALL NOT recheck them after latching.
REQ-022 stallreq_o SHALL equal (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), combinationally.
REQ-023 An 8-bit wait counter SHALL clear on grant and increment each granted cycle with bus_ack_i=0.
REQ-024 When the counter reaches TIMEOUT_CYCLES, the arbiter SHALL force completion: x_ack_o pulse, x_rdata_o=0, err_o pulse, bus_req_o low next cycle, and a return to IDLE.
REQ-025 bus_ack_i=1 in the timeout cycle SHALL complete normally with no err_o.
REQ-026 bus_ack_i in IDLE SHALL be ignored.

Reset
REQ-027 rst low SHALL immediately force state IDLE, last_gnt=IF, counter=0, and all outputs 0 (stallreq_o follows inputs).
REQ-028 Reset mid-grant SHALL abandon the bus access with no ack or err pulse; the requester reissues after reset release.

Structure
REQ-029 The shared package SHALL hold the FSM state enum, ADDR_W=32, DATA_W=32 and SEL_W=4.
REQ-030 The block SHALL be a single module with no sub-modules; the counter and FSM are inline.

Verification
REQ-031 Test: rst low, then high with if_req_i=1 and bus_ack_i tied high. Required: bus_req_o high the cycle after the request, if_ack_o the following cycle, if_rdata_o=bus_rdata_i (0x24020001).
REQ-032 Test: if_req_i and dm_req_i raised in the same cycle, each held until its ack. Required: DM served first, then IF, with no cycle where both acks are high.
REQ-033 Test: DM write (we=1, sel=4'b0011, addr 0x100, wdata 0xDEADBEEF) with bus_ack_i after 3 cycles. Required: bus_we_o=1, bus_sel_o=0011, bus_wdata_o=DEADBEEF, stallreq_o high until dm_ack_o, dm_rdata_o unchanged.
REQ-034 Test: TIMEOUT_CYCLES=4 with bus_ack_i never asserted. Required: if_ack_o and err_o pulse after 4 wait cycles, if_rdata_o=0, FSM back in IDLE.
REQ-035 Test: rst asserted in the second GNT_DM cycle. Required: bus_req_o, dm_ack_o and err_o all 0 immediately, and a request after release is served normally.
